ctrl_fsm_multicycle: RTL and testbench

Parametrised multicycle control FSM for the RV32 core. It sequences fetch, decode, execute, memory and writeback, and drives the PC, IMem, register-file and DMem enables. Memory latency is configurable: either a fixed wait-state count or an ack handshake. It also adds fence drain timing and a sticky halt. It sits between the decoder and the datapath/memory enables.

---
 rtl/ctrl_fsm_multicycle.sv | 240 ++++++++++++++++++++++++
 tb/tb_ctrl_fsm_multicycle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_multicycle.sv
// Multicycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing with fixed-latency or ack-terminated waits.
// Optional performance counters are enabled by defining CTRL_FSM_PERF_EN.
module ctrl_fsm_multicycle #(
    parameter int STRB_W       = 4,
    parameter int USE_ACK      = 0,
    parameter int IMEM_LAT     = 1,
    parameter int DMEM_LAT     = 1,
    parameter int FENCE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              store,
    input  logic              branch,
    input  logic              fence,
    input  logic              halt,
    input  logic [STRB_W-1:0] decoder_dmem_we,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              pc_we,
    output logic              imem_rd,
    output logic              rf_we,
    output logic [STRB_W-1:0] dmem_we,
    output logic              dmem_rd,
    output logic [3:0]        state,
    output logic              halted
`ifdef CTRL_FSM_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_FWAIT  = 4'd2,
        ST_DECODE = 4'd3,
        ST_EXEC   = 4'd4,
        ST_MEM    = 4'd5,
        ST_MWAIT  = 4'd6,
        ST_WB     = 4'd7,
        ST_FENCE  = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam int              CNT_W      = $clog2(256);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Counters hold "remaining cycles after this one", so a load of N-1 yields N wait cycles.
    localparam logic [CNT_W-1:0] IMEM_WAIT  = (IMEM_LAT > 0) ? CNT_W'(IMEM_LAT - 1) : CNT_ZERO;
    localparam logic [CNT_W-1:0] DMEM_WAIT  = (DMEM_LAT > 0) ? CNT_W'(DMEM_LAT - 1) : CNT_ZERO;
    localparam logic [CNT_W-1:0] FENCE_WAIT = (FENCE_CYCLES > 0) ? CNT_W'(FENCE_CYCLES - 1) : CNT_ZERO;
    localparam bit              ACK_MODE   = (USE_ACK != 0);
    localparam logic [STRB_W-1:0] STRB_ZERO = {STRB_W{1'b0}};

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              is_load_r, is_load_s, is_store_r, is_store_s;
    logic              is_branch_r, is_branch_s, is_fence_r, is_fence_s;
    logic [STRB_W-1:0] strb_r, strb_s;
    logic              pc_we_r, pc_we_s, imem_rd_r, imem_rd_s, rf_we_r, rf_we_s;
    logic              dmem_rd_r, dmem_rd_s, halted_r, halted_s;
    logic [STRB_W-1:0] dmem_we_r, dmem_we_s;

    // Next-state, wait counter and instruction-class latch logic.
    always_comb begin
        state_s     = state_r;
        cnt_s       = (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : CNT_ZERO;
        is_load_s   = is_load_r;
        is_store_s  = is_store_r;
        is_branch_s = is_branch_r;
        is_fence_s  = is_fence_r;
        strb_s      = strb_r;
        case (state_r)
            ST_RESET: state_s = ST_FETCH;
            ST_FETCH: begin
                if (ACK_MODE) begin
                    if (imem_ack) state_s = ST_DECODE;
                    else          state_s = ST_FWAIT;
                end else if (IMEM_LAT > 0) begin
                    state_s = ST_FWAIT;
                    cnt_s   = IMEM_WAIT;
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_FWAIT: begin
                if (ACK_MODE) begin
                    if (imem_ack) state_s = ST_DECODE;
                    else          state_s = ST_FWAIT;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FWAIT;
                end
            end
            ST_DECODE: begin
                // Priority halt > fence > load > store; only a pure store keeps its strobe.
                is_load_s   = ~halt & ~fence & load;
                is_store_s  = ~halt & ~fence & ~load & store;
                is_fence_s  = ~halt & fence;
                is_branch_s = ~halt & ~fence & ~load & ~store & branch;
                strb_s      = (~halt & ~fence & ~load & store) ? decoder_dmem_we : STRB_ZERO;
                if (halt) begin
                    state_s = ST_HALT;
                end else if (fence) begin
                    state_s = ST_FENCE;
                    cnt_s   = FENCE_WAIT;
                end else if (load | store) begin
                    state_s = ST_MEM;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: state_s = ST_WB;
            ST_MEM: begin
                if (ACK_MODE) begin
                    if (dmem_ack) state_s = ST_WB;
                    else          state_s = ST_MWAIT;
                end else if (DMEM_LAT > 0) begin
                    state_s = ST_MWAIT;
                    cnt_s   = DMEM_WAIT;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_MWAIT: begin
                if (ACK_MODE) begin
                    if (dmem_ack) state_s = ST_WB;
                    else          state_s = ST_MWAIT;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_MWAIT;
                end
            end
            ST_FENCE: begin
                if (cnt_r == CNT_ZERO) state_s = ST_WB;
                else                   state_s = ST_FENCE;
            end
            ST_WB:   state_s = ST_FETCH;
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_RESET;
        endcase
    end

    // Moore output decode of the upcoming state, so the enables can be registered alongside it.
    always_comb begin
        pc_we_s   = 1'b0;
        imem_rd_s = 1'b0;
        rf_we_s   = 1'b0;
        dmem_we_s = STRB_ZERO;
        dmem_rd_s = 1'b0;
        halted_s  = 1'b0;
        case (state_s)
            ST_FETCH: imem_rd_s = 1'b1;
            ST_FWAIT: imem_rd_s = ACK_MODE;
            ST_MEM: begin
                dmem_rd_s = is_load_s;
                dmem_we_s = is_store_s ? strb_s : STRB_ZERO;
            end
            ST_MWAIT: begin
                if (ACK_MODE) begin
                    dmem_rd_s = is_load_s;
                    dmem_we_s = is_store_s ? strb_s : STRB_ZERO;
                end else begin
                    dmem_rd_s = 1'b0;
                    dmem_we_s = STRB_ZERO;
                end
            end
            ST_WB: begin
                pc_we_s = 1'b1;
                rf_we_s = ~(is_store_s | is_branch_s | is_fence_s);
            end
            ST_HALT: halted_s = 1'b1;
            default: pc_we_s = 1'b0;
        endcase
    end

    // State, counter, class latches and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RESET;
            cnt_r       <= CNT_ZERO;
            is_load_r   <= 1'b0;
            is_store_r  <= 1'b0;
            is_branch_r <= 1'b0;
            is_fence_r  <= 1'b0;
            strb_r      <= STRB_ZERO;
            pc_we_r     <= 1'b0;
            imem_rd_r   <= 1'b0;
            rf_we_r     <= 1'b0;
            dmem_we_r   <= STRB_ZERO;
            dmem_rd_r   <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            is_load_r   <= is_load_s;
            is_store_r  <= is_store_s;
            is_branch_r <= is_branch_s;
            is_fence_r  <= is_fence_s;
            strb_r      <= strb_s;
            pc_we_r     <= pc_we_s;
            imem_rd_r   <= imem_rd_s;
            rf_we_r     <= rf_we_s;
            dmem_we_r   <= dmem_we_s;
            dmem_rd_r   <= dmem_rd_s;
            halted_r    <= halted_s;
        end
    end

    assign pc_we   = pc_we_r;
    assign imem_rd = imem_rd_r;
    assign rf_we   = rf_we_r;
    assign dmem_we = dmem_we_r;
    assign dmem_rd = dmem_rd_r;
    assign halted  = halted_r;
    assign state   = state_r;

`ifdef CTRL_FSM_PERF_EN
    logic [31:0] cycle_cnt_r, instret_cnt_r;

    // Active-cycle and retired-instruction counters, both wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_r   <= 32'd0;
            instret_cnt_r <= 32'd0;
        end else begin
            if ((state_r != ST_RESET) && (state_r != ST_HALT)) cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (state_r == ST_WB) instret_cnt_r <= instret_cnt_r + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_ctrl_fsm_multicycle.sv
// Bench for ctrl_fsm_multicycle: per-instruction expected cycle traces for a fixed-latency and an ack-mode instance.
module tb_ctrl_fsm_multicycle;

    localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_FWAIT = 4'd2, S_DECODE = 4'd3,
                           S_EXEC = 4'd4, S_MEM = 4'd5, S_MWAIT = 4'd6, S_WB = 4'd7,
                           S_FENCE = 4'd8, S_HALT = 4'd9;
    // Fixed instance latencies (instance 0); instance 1 is ack mode with FENCE_CYCLES=0.
    localparam int FX_IL = 1, FX_DL = 2, FX_FC = 2;

    typedef struct {
        bit         chk;
        logic       rst;
        logic [3:0] st;
        logic [8:0] outs;
        logic       ld, sto, br, fe, ht;
        logic [3:0] strb;
        logic       ia, da;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v[2], ld_v[2], st_v[2], br_v[2], fe_v[2], ht_v[2], ia_v[2], da_v[2];
    logic [3:0] strb_v[2];
    logic       pc_we_o[2], imem_rd_o[2], rf_we_o[2], dmem_rd_o[2], halted_o[2];
    logic [3:0] dmem_we_o[2], state_o[2];
`ifdef CTRL_FSM_PERF_EN
    logic [31:0] cyc_o[2], ins_o[2];
    logic [31:0] exp_cyc[2], exp_ins[2];
`endif

    cyc_t q0[$], q1[$];
    int   checks = 0;
    int   errors = 0;
    logic g_ld, g_st, g_br, g_fe, g_ht;
    logic [3:0] g_strb;

    ctrl_fsm_multicycle #(.STRB_W(4), .USE_ACK(0), .IMEM_LAT(FX_IL), .DMEM_LAT(FX_DL), .FENCE_CYCLES(FX_FC)) u_fix (
        .clk(clk), .rst(rst_v[0]), .load(ld_v[0]), .store(st_v[0]), .branch(br_v[0]), .fence(fe_v[0]),
        .halt(ht_v[0]), .decoder_dmem_we(strb_v[0]), .imem_ack(ia_v[0]), .dmem_ack(da_v[0]),
        .pc_we(pc_we_o[0]), .imem_rd(imem_rd_o[0]), .rf_we(rf_we_o[0]), .dmem_we(dmem_we_o[0]),
        .dmem_rd(dmem_rd_o[0]), .state(state_o[0]), .halted(halted_o[0])
`ifdef CTRL_FSM_PERF_EN
        , .cycle_cnt(cyc_o[0]), .instret_cnt(ins_o[0])
`endif
    );

    ctrl_fsm_multicycle #(.STRB_W(4), .USE_ACK(1), .IMEM_LAT(1), .DMEM_LAT(1), .FENCE_CYCLES(0)) u_ack (
        .clk(clk), .rst(rst_v[1]), .load(ld_v[1]), .store(st_v[1]), .branch(br_v[1]), .fence(fe_v[1]),
        .halt(ht_v[1]), .decoder_dmem_we(strb_v[1]), .imem_ack(ia_v[1]), .dmem_ack(da_v[1]),
        .pc_we(pc_we_o[1]), .imem_rd(imem_rd_o[1]), .rf_we(rf_we_o[1]), .dmem_we(dmem_we_o[1]),
        .dmem_rd(dmem_rd_o[1]), .state(state_o[1]), .halted(halted_o[1])
`ifdef CTRL_FSM_PERF_EN
        , .cycle_cnt(cyc_o[1]), .instret_cnt(ins_o[1])
`endif
    );

    function automatic logic [8:0] o(input logic pc, input logic ird, input logic rf,
                                     input logic [3:0] dwe, input logic drd, input logic hl);
        return {pc, ird, rf, dwe, drd, hl};
    endfunction

    // ack code: 0/1 drive that value, 2 drive a random value (ack ignored in that state)
    task automatic push(input int sel, input bit chk, input logic [3:0] st, input logic [8:0] outs,
                        input logic rs, input bit dec, input int ia, input int da);
        cyc_t r;
        r.chk = chk; r.rst = rs; r.st = st; r.outs = outs;
        if (dec) begin
            r.ld = g_ld; r.sto = g_st; r.br = g_br; r.fe = g_fe; r.ht = g_ht; r.strb = g_strb;
        end else begin
            r.ld = 1'($urandom); r.sto = 1'($urandom); r.br = 1'($urandom);
            r.fe = 1'($urandom); r.ht = 1'($urandom); r.strb = 4'($urandom);
        end
        r.ia = (ia == 2) ? 1'($urandom) : 1'(ia);
        r.da = (da == 2) ? 1'($urandom) : 1'(da);
        if (sel == 0) q0.push_back(r);
        else          q1.push_back(r);
    endtask

    // Expected trace of one instruction. id/dd: ack delays (ack mode); rst_mw: reset in first MWAIT cycle.
    task automatic gen_instr(input int sel, input bit ld, input bit st, input bit br, input bit fe,
                             input bit ht, input logic [3:0] strb, input int id, input int dd, input bit rst_mw);
        logic [3:0] dwe;
        logic [8:0] mo, wo;
        int nh, nf, ndl;
        g_ld = ld; g_st = st; g_br = br; g_fe = fe; g_ht = ht; g_strb = strb;
        if (sel == 0) begin
            push(sel, 1, S_FETCH, o(0,1,0,4'h0,0,0), 0, 0, 2, 2);
            for (int i = 0; i < FX_IL; i++) push(sel, 1, S_FWAIT, 9'd0, 0, 0, 2, 2);
        end else begin
            push(sel, 1, S_FETCH, o(0,1,0,4'h0,0,0), 0, 0, (id == 0) ? 1 : 0, 2);
            for (int i = 0; i < id; i++)
                push(sel, 1, S_FWAIT, o(0,1,0,4'h0,0,0), 0, 0, (i == id - 1) ? 1 : 0, 2);
        end
        push(sel, 1, S_DECODE, 9'd0, 0, 1, 2, 2);
        if (ht) begin
            nh = $urandom_range(1, 4);
            for (int i = 0; i < nh; i++) push(sel, 1, S_HALT, o(0,0,0,4'h0,0,1), 0, 0, 2, 2);
            push(sel, 1, S_HALT, o(0,0,0,4'h0,0,1), 1, 0, 2, 2);
            push(sel, 1, S_RESET, 9'd0, 0, 0, 2, 2);
            return;
        end
        if (fe) begin
            nf = (sel == 0) ? FX_FC : 1;
            for (int i = 0; i < nf; i++) push(sel, 1, S_FENCE, 9'd0, 0, 0, 2, 2);
            push(sel, 1, S_WB, o(1,0,0,4'h0,0,0), 0, 0, 2, 2);
        end else if (ld | st) begin
            dwe = ld ? 4'h0 : strb;
            mo  = o(0,0,0,dwe,ld,0);
            ndl = (sel == 0) ? FX_DL : dd;
            push(sel, 1, S_MEM, mo, 0, 0, 2, (sel == 0) ? 2 : ((dd == 0) ? 1 : 0));
            wo = (sel == 0) ? 9'd0 : mo;
            for (int i = 0; i < ndl; i++) begin
                if (rst_mw && i == 0) begin
                    push(sel, 1, S_MWAIT, wo, 1, 0, 2, (sel == 0) ? 2 : 0);
                    push(sel, 1, S_RESET, 9'd0, 0, 0, 2, 2);
                    return;
                end
                push(sel, 1, S_MWAIT, wo, 0, 0, 2, (sel == 0) ? 2 : ((i == ndl - 1) ? 1 : 0));
            end
            push(sel, 1, S_WB, o(1,0,ld,4'h0,0,0), 0, 0, 2, 2);
        end else begin
            push(sel, 1, S_EXEC, 9'd0, 0, 0, 2, 2);
            push(sel, 1, S_WB, o(1,0,~br,4'h0,0,0), 0, 0, 2, 2);
        end
    endtask

    task automatic gen_random(input int sel);
        bit ld, st, br, fe, ht, rm;
        ht = ($urandom_range(0, 19) == 0);
        fe = ($urandom_range(0, 5) == 0);
        ld = ($urandom_range(0, 2) == 0);
        st = ($urandom_range(0, 2) == 0);
        br = 1'($urandom);
        rm = ($urandom_range(0, 9) == 0);
        gen_instr(sel, ld, st, br, fe, ht, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rm);
    endtask

    task automatic pin(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int sel, input cyc_t r);
        logic [8:0] act;
        if (r.chk) begin
            act = {pc_we_o[sel], imem_rd_o[sel], rf_we_o[sel], dmem_we_o[sel], dmem_rd_o[sel], halted_o[sel]};
            checks++;
            if (state_o[sel] !== r.st || act !== r.outs) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t: state=%0d outs=%b, expected state=%0d outs=%b",
                         sel, $time, state_o[sel], act, r.st, r.outs);
            end
`ifdef CTRL_FSM_PERF_EN
            checks++;
            if (cyc_o[sel] !== exp_cyc[sel] || ins_o[sel] !== exp_ins[sel]) begin
                errors++;
                $display("FAIL perf dut%0d t=%0t: cycle=%0d instret=%0d, expected cycle=%0d instret=%0d",
                         sel, $time, cyc_o[sel], ins_o[sel], exp_cyc[sel], exp_ins[sel]);
            end
            if (r.rst) begin
                exp_cyc[sel] = 32'd0; exp_ins[sel] = 32'd0;
            end else begin
                if (r.st != S_RESET && r.st != S_HALT) exp_cyc[sel] = exp_cyc[sel] + 32'd1;
                if (r.st == S_WB) exp_ins[sel] = exp_ins[sel] + 32'd1;
            end
`endif
        end else begin
`ifdef CTRL_FSM_PERF_EN
            exp_cyc[sel] = 32'd0; exp_ins[sel] = 32'd0;
`endif
        end
        rst_v[sel] = r.rst; ld_v[sel] = r.ld; st_v[sel] = r.sto; br_v[sel] = r.br;
        fe_v[sel] = r.fe; ht_v[sel] = r.ht; strb_v[sel] = r.strb; ia_v[sel] = r.ia; da_v[sel] = r.da;
    endtask

    initial begin
        int n;
        cyc_t r;
        for (int s = 0; s < 2; s++) begin
            rst_v[s] = 1'b1; ld_v[s] = 1'b0; st_v[s] = 1'b0; br_v[s] = 1'b0; fe_v[s] = 1'b0;
            ht_v[s] = 1'b0; strb_v[s] = 4'h0; ia_v[s] = 1'b0; da_v[s] = 1'b0;
            push(s, 0, S_RESET, 9'd0, 1, 0, 0, 0);
            push(s, 1, S_RESET, 9'd0, 0, 0, 0, 0);
        end
        // Fixed-latency directed traces, lengths pinned to hand-computed cycle counts
        n = q0.size(); gen_instr(0, 0,0,0,0,0, 4'h0, 0,0,0); pin("alu_fixed_len",   q0.size() - n, 5);
        n = q0.size(); gen_instr(0, 0,1,0,0,0, 4'hF, 0,0,0); pin("store_fixed_len", q0.size() - n, 7);
        n = q0.size(); gen_instr(0, 1,0,0,0,0, 4'h3, 0,0,0); pin("load_fixed_len",  q0.size() - n, 7);
        n = q0.size(); gen_instr(0, 1,0,1,1,0, 4'h5, 0,0,0); pin("fence_fixed_len", q0.size() - n, 6);
        n = q0.size(); gen_instr(0, 0,1,0,0,0, 4'hA, 0,0,1); pin("store_rst_len",   q0.size() - n, 6);
        gen_instr(0, 1,1,0,0,1, 4'hF, 0,0,0);
        // Ack-mode directed traces
        n = q1.size(); gen_instr(1, 1,0,0,0,0, 4'h0, 0,3,0); pin("load_ack_len",    q1.size() - n, 7);
        n = q1.size(); gen_instr(1, 0,1,0,0,0, 4'hF, 2,1,0); pin("store_ack_len",   q1.size() - n, 7);
        n = q1.size(); gen_instr(1, 0,0,0,1,0, 4'h0, 0,0,0); pin("fence_ack_len",   q1.size() - n, 4);
        gen_instr(1, 0,1,0,0,0, 4'h9, 1,2,1);
        gen_instr(1, 1,1,0,0,1, 4'hF, 1,0,0);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (((s == 0) ? q0.size() : q1.size()) < 16) gen_random(s);
                if (s == 0) r = q0.pop_front();
                else        r = q1.pop_front();
                step(s, r);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
